// File: rtl/life_frame_scheduler_pkg.sv
// Shared types and defaults for the Game-of-Life frame scheduler.
// Holds the FSM state encoding and the default grid geometry.
package life_sched_pkg;

  localparam int ADDR_W_DEF = 6;
  localparam int DATA_W_DEF = 1;
  localparam int GEN_W      = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    READY   = 2'd2
  } sched_state_e;

endpackage

// File: rtl/life_frame_scheduler_grid_port_mux.sv
// Single-port grid RAM arbiter: display has priority, engine only inside its compute window.
// Reads come from the front bank, engine writes land in the back bank.
module grid_port_mux
  import life_sched_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              eng_window,
  input  logic              front_bank,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic [DATA_W-1:0] disp_rdata,
  output logic              disp_rvalid,
  input  logic              eng_req,
  input  logic              eng_we,
  input  logic [ADDR_W-1:0] eng_addr,
  input  logic [DATA_W-1:0] eng_wdata,
  output logic              eng_gnt,
  output logic [DATA_W-1:0] eng_rdata,
  output logic              eng_rvalid,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W:0]   mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  logic disp_gnt;
  logic disp_rvalid_d, disp_rvalid_q;
  logic eng_rvalid_d, eng_rvalid_q;

  // Nothing reaches the RAM while reset is held, whatever state the FSM is leaving.
  always_comb begin
    disp_gnt  = 1'b0;
    eng_gnt   = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (reset_n) begin
      if (disp_req) begin
        disp_gnt = 1'b1;
        mem_en   = 1'b1;
        mem_addr = {front_bank, disp_addr};
      end else if (eng_req && eng_window) begin
        eng_gnt = 1'b1;
        mem_en  = 1'b1;
        if (eng_we) begin
          mem_we    = 1'b1;
          mem_addr  = {~front_bank, eng_addr};
          mem_wdata = eng_wdata;
        end else begin
          mem_addr = {front_bank, eng_addr};
        end
      end
    end
  end

  always_comb begin
    disp_rvalid_d = disp_gnt;
    eng_rvalid_d  = eng_gnt && !eng_we;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      disp_rvalid_q <= 1'b0;
      eng_rvalid_q  <= 1'b0;
    end else begin
      disp_rvalid_q <= disp_rvalid_d;
      eng_rvalid_q  <= eng_rvalid_d;
    end
  end

  assign disp_rvalid = disp_rvalid_q;
  assign eng_rvalid  = eng_rvalid_q;
  assign disp_rdata  = mem_rdata;
  assign eng_rdata   = mem_rdata;

endmodule

// File: rtl/life_frame_scheduler.sv
// Paces Game-of-Life generations to the VGA frame and swaps the double-buffered
// grid banks only at a frame boundary so the display never tears.
module life_frame_scheduler
  import life_sched_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int GEN_DIV = 30
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              frame_start,
  input  logic              run,
  input  logic              step,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic [DATA_W-1:0] disp_rdata,
  output logic              disp_rvalid,
  input  logic              eng_req,
  input  logic              eng_we,
  input  logic [ADDR_W-1:0] eng_addr,
  input  logic [DATA_W-1:0] eng_wdata,
  output logic              eng_gnt,
  output logic [DATA_W-1:0] eng_rdata,
  output logic              eng_rvalid,
  output logic              gen_start,
  input  logic              gen_done,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W:0]   mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              front_bank,
  output logic [15:0]       generation,
  output logic              overrun
);

  localparam int DIV_W = (GEN_DIV > 1) ? $clog2(GEN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(GEN_DIV - 1);

  sched_state_e     state_d, state_q;
  logic [DIV_W-1:0] div_cnt_d, div_cnt_q;
  logic             step_pend_d, step_pend_q;
  logic             front_bank_d, front_bank_q;
  logic [GEN_W-1:0] generation_d, generation_q;
  logic             overrun_d, overrun_q;
  logic             gen_start_d, gen_start_q;
  logic             div_hit;
  logic             due;

  assign div_hit = run && (div_cnt_q == DIV_LAST);
  assign due     = frame_start && (div_hit || step_pend_q);

  // A due trigger while computing is dropped and flagged; READY's frame only swaps.
  always_comb begin
    state_d      = state_q;
    div_cnt_d    = div_cnt_q;
    step_pend_d  = step_pend_q;
    front_bank_d = front_bank_q;
    generation_d = generation_q;
    overrun_d    = overrun_q;
    gen_start_d  = 1'b0;

    if (frame_start && run) begin
      div_cnt_d = div_hit ? '0 : div_cnt_q + DIV_W'(1);
    end
    if (step && !run) begin
      step_pend_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (due) begin
          state_d     = COMPUTE;
          gen_start_d = 1'b1;
          step_pend_d = 1'b0;
        end
      end
      COMPUTE: begin
        if (gen_done) begin
          state_d = READY;
        end else if (due) begin
          overrun_d = 1'b1;
        end
      end
      READY: begin
        if (frame_start) begin
          state_d      = IDLE;
          front_bank_d = ~front_bank_q;
          generation_d = generation_q + GEN_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      div_cnt_q    <= '0;
      step_pend_q  <= 1'b0;
      front_bank_q <= 1'b0;
      generation_q <= '0;
      overrun_q    <= 1'b0;
      gen_start_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      div_cnt_q    <= div_cnt_d;
      step_pend_q  <= step_pend_d;
      front_bank_q <= front_bank_d;
      generation_q <= generation_d;
      overrun_q    <= overrun_d;
      gen_start_q  <= gen_start_d;
    end
  end

  assign front_bank = front_bank_q;
  assign generation = generation_q;
  assign overrun    = overrun_q;
  assign gen_start  = gen_start_q;

  grid_port_mux #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_port_mux (
    .clk        (clk),
    .reset_n    (reset_n),
    .eng_window (state_q == COMPUTE),
    .front_bank (front_bank_q),
    .disp_req   (disp_req),
    .disp_addr  (disp_addr),
    .disp_rdata (disp_rdata),
    .disp_rvalid(disp_rvalid),
    .eng_req    (eng_req),
    .eng_we     (eng_we),
    .eng_addr   (eng_addr),
    .eng_wdata  (eng_wdata),
    .eng_gnt    (eng_gnt),
    .eng_rdata  (eng_rdata),
    .eng_rvalid (eng_rvalid),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

endmodule

// File: tb/tb_life_frame_scheduler.sv
// Directed bench for life_frame_scheduler with GEN_DIV=2 and a parity-pattern RAM model.
module tb_life_frame_scheduler;

  logic        clk;
  logic        reset_n;
  logic        frame_start;
  logic        run;
  logic        step;
  logic        disp_req;
  logic [5:0]  disp_addr;
  logic [0:0]  disp_rdata;
  logic        disp_rvalid;
  logic        eng_req;
  logic        eng_we;
  logic [5:0]  eng_addr;
  logic [0:0]  eng_wdata;
  logic        eng_gnt;
  logic [0:0]  eng_rdata;
  logic        eng_rvalid;
  logic        gen_start;
  logic        gen_done;
  logic        mem_en;
  logic        mem_we;
  logic [6:0]  mem_addr;
  logic [0:0]  mem_wdata;
  logic [0:0]  mem_rdata;
  logic        front_bank;
  logic [15:0] generation;
  logic        overrun;

  int vectors;
  int miscompares;

  life_frame_scheduler #(
    .ADDR_W (6),
    .DATA_W (1),
    .GEN_DIV(2)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .frame_start(frame_start),
    .run        (run),
    .step       (step),
    .disp_req   (disp_req),
    .disp_addr  (disp_addr),
    .disp_rdata (disp_rdata),
    .disp_rvalid(disp_rvalid),
    .eng_req    (eng_req),
    .eng_we     (eng_we),
    .eng_addr   (eng_addr),
    .eng_wdata  (eng_wdata),
    .eng_gnt    (eng_gnt),
    .eng_rdata  (eng_rdata),
    .eng_rvalid (eng_rvalid),
    .gen_start  (gen_start),
    .gen_done   (gen_done),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .front_bank (front_bank),
    .generation (generation),
    .overrun    (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM stand-in: read data is the parity of the address, one cycle after the read.
  always @(posedge clk) begin
    if (mem_en && !mem_we) mem_rdata <= ^mem_addr;
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic pulseFrame();
    frame_start = 1'b1;
    cycle();
    frame_start = 1'b0;
  endtask

  task automatic pulseGenDone();
    gen_done = 1'b1;
    cycle();
    gen_done = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    mem_rdata = '0;
    reset_n = 1'b0; frame_start = 1'b0; run = 1'b0; step = 1'b0;
    disp_req = 1'b1; disp_addr = '0;
    eng_req = 1'b0; eng_we = 1'b0; eng_addr = '0; eng_wdata = '0;
    gen_done = 1'b0;

    cycle(); cycle(); settle();
    checkOutput("rst_mem_en", 32'(mem_en), 32'd0);
    checkOutput("rst_front_bank", 32'(front_bank), 32'd0);
    checkOutput("rst_generation", 32'(generation), 32'd0);
    checkOutput("rst_overrun", 32'(overrun), 32'd0);
    checkOutput("rst_gen_start", 32'(gen_start), 32'd0);
    checkOutput("rst_disp_rvalid", 32'(disp_rvalid), 32'd0);
    disp_req = 1'b0; reset_n = 1'b1;
    cycle();

    run = 1'b1;
    pulseFrame();
    checkOutput("run_frame1_no_start", 32'(gen_start), 32'd0);
    pulseFrame();
    checkOutput("run_frame2_start", 32'(gen_start), 32'd1);
    cycle();
    checkOutput("gen_start_one_cycle", 32'(gen_start), 32'd0);

    disp_req = 1'b1; disp_addr = 6'h2A;
    eng_req = 1'b1; eng_we = 1'b0; eng_addr = 6'h05;
    settle();
    checkOutput("arb_disp_addr", 32'(mem_addr), 32'h2A);
    checkOutput("arb_eng_blocked", 32'(eng_gnt), 32'd0);
    checkOutput("arb_disp_en", 32'(mem_en), 32'd1);
    checkOutput("arb_disp_we", 32'(mem_we), 32'd0);
    cycle();
    checkOutput("disp_rvalid", 32'(disp_rvalid), 32'd1);
    checkOutput("disp_rdata", 32'(disp_rdata), 32'd1);
    checkOutput("eng_rvalid_idle", 32'(eng_rvalid), 32'd0);
    disp_req = 1'b0;
    settle();
    checkOutput("eng_read_gnt", 32'(eng_gnt), 32'd1);
    checkOutput("eng_read_addr", 32'(mem_addr), 32'h05);
    cycle();
    eng_req = 1'b0;
    checkOutput("eng_rvalid", 32'(eng_rvalid), 32'd1);
    checkOutput("eng_rdata", 32'(eng_rdata), 32'd0);
    checkOutput("disp_rvalid_drop", 32'(disp_rvalid), 32'd0);
    eng_req = 1'b1; eng_we = 1'b1; eng_addr = 6'h03; eng_wdata = 1'b1;
    settle();
    checkOutput("eng_write_addr_b0", 32'(mem_addr), 32'h43);
    checkOutput("eng_write_we_b0", 32'(mem_we), 32'd1);
    cycle();
    eng_req = 1'b0; eng_we = 1'b0;
    checkOutput("no_rvalid_after_write", 32'(eng_rvalid), 32'd0);

    repeat (100) cycle();
    pulseGenDone();
    checkOutput("no_swap_before_frame", 32'(front_bank), 32'd0);
    pulseFrame();
    checkOutput("swap1_front_bank", 32'(front_bank), 32'd1);
    checkOutput("swap1_generation", 32'(generation), 32'd1);
    checkOutput("swap_frame_no_start", 32'(gen_start), 32'd0);
    pulseFrame();
    checkOutput("run_frame4_start", 32'(gen_start), 32'd1);
    cycle();

    eng_req = 1'b1; eng_we = 1'b1; eng_addr = 6'h03; eng_wdata = 1'b1;
    settle();
    checkOutput("eng_write_addr_b1", 32'(mem_addr), 32'h03);
    checkOutput("eng_write_we_b1", 32'(mem_we), 32'd1);
    checkOutput("eng_write_data_b1", 32'(mem_wdata), 32'd1);
    disp_req = 1'b1; disp_addr = 6'h03;
    settle();
    checkOutput("disp_reads_bank1", 32'(mem_addr), 32'h43);
    checkOutput("disp_blocks_write", 32'(eng_gnt), 32'd0);
    cycle();
    disp_req = 1'b0;
    cycle();
    eng_req = 1'b0; eng_we = 1'b0;

    pulseFrame();
    checkOutput("no_overrun_yet", 32'(overrun), 32'd0);
    pulseFrame();
    checkOutput("overrun_set", 32'(overrun), 32'd1);
    checkOutput("overrun_no_start", 32'(gen_start), 32'd0);
    repeat (3) cycle();
    checkOutput("overrun_sticky", 32'(overrun), 32'd1);
    pulseGenDone();
    pulseFrame();
    checkOutput("swap2_front_bank", 32'(front_bank), 32'd0);
    checkOutput("swap2_generation", 32'(generation), 32'd2);
    checkOutput("overrun_kept", 32'(overrun), 32'd1);

    run = 1'b0;
    cycle();
    step = 1'b1;
    cycle();
    step = 1'b0;
    checkOutput("step_waits_frame", 32'(gen_start), 32'd0);
    pulseFrame();
    checkOutput("step_start", 32'(gen_start), 32'd1);
    cycle();
    checkOutput("step_start_pulse", 32'(gen_start), 32'd0);
    pulseGenDone();
    pulseFrame();
    checkOutput("step_generation", 32'(generation), 32'd3);
    checkOutput("step_front_bank", 32'(front_bank), 32'd1);
    pulseFrame();
    checkOutput("step_only_once", 32'(gen_start), 32'd0);
    checkOutput("step_gen_held", 32'(generation), 32'd3);

    step = 1'b1;
    cycle();
    step = 1'b0;
    pulseFrame();
    checkOutput("step2_start", 32'(gen_start), 32'd1);
    eng_req = 1'b1; eng_we = 1'b0; eng_addr = 6'h05;
    settle();
    checkOutput("compute_eng_gnt", 32'(eng_gnt), 32'd1);
    reset_n = 1'b0; disp_req = 1'b1;
    settle();
    checkOutput("rst_gate_en", 32'(mem_en), 32'd0);
    checkOutput("rst_gate_gnt", 32'(eng_gnt), 32'd0);
    cycle();
    reset_n = 1'b1; disp_req = 1'b0;
    settle();
    checkOutput("midrst_front_bank", 32'(front_bank), 32'd0);
    checkOutput("midrst_generation", 32'(generation), 32'd0);
    checkOutput("midrst_overrun", 32'(overrun), 32'd0);
    checkOutput("midrst_gen_start", 32'(gen_start), 32'd0);
    checkOutput("midrst_disp_rvalid", 32'(disp_rvalid), 32'd0);
    checkOutput("midrst_eng_rvalid", 32'(eng_rvalid), 32'd0);
    checkOutput("idle_eng_not_granted", 32'(eng_gnt), 32'd0);
    cycle();
    checkOutput("idle_no_eng_rvalid", 32'(eng_rvalid), 32'd0);
    eng_req = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/life_frame_scheduler.md
# life_frame_scheduler

Sequences Game-of-Life generations against the VGA frame and shares the single-port, double-buffered cell-grid RAM between the display pixel fetch and the life update engine. The display always reads the front bank. The engine reads the front bank and writes the back bank. Banks swap only on a frame boundary, so the picture never tears. The block sits between the VGA timing generator (source of `frame_start`), the update engine, and the grid RAM.

## Interface
Parameters:
- `ADDR_W`, 6, cell address width within one bank (6x6 grid uses 36 of 64).
- `DATA_W`, 1, cell state width.
- `GEN_DIV`, 30, frames per generation in run mode; must be ≥1.

Ports:
- `clk`  in  1  pixel clock.
- `reset_n`  in  1  synchronous, active-low reset.
- `frame_start`  in  1  one-cycle pulse at start of vertical blanking.
- `run`  in  1  level; free-running generations.
- `step`  in  1  pulse; request one generation while `run`=0.
- `disp_req`  in  1  display read request.
- `disp_addr`  in  ADDR_W  display cell address.
- `disp_rdata`  out  DATA_W  display read data.
- `disp_rvalid`  out  1  display read data valid.
- `eng_req`  in  1  engine access request.
- `eng_we`  in  1  engine access is a write.
- `eng_addr`  in  ADDR_W  engine cell address.
- `eng_wdata`  in  DATA_W  engine write data.
- `eng_gnt`  out  1  engine access accepted this cycle.
- `eng_rdata`  out  DATA_W  engine read data.
- `eng_rvalid`  out  1  engine read data valid.
- `gen_start`  out  1  one-cycle pulse; engine begins a generation.
- `gen_done`  in  1  one-cycle pulse; engine finished writing the back bank.
- `mem_en`  out  1  RAM port enable.
- `mem_we`  out  1  RAM write enable.
- `mem_addr`  out  ADDR_W+1  RAM address; MSB is the bank.
- `mem_wdata`  out  DATA_W  RAM write data.
- `mem_rdata`  in  DATA_W  RAM read data; 1-cycle read latency.
- `front_bank`  out  1  bank currently displayed.
- `generation`  out  16  count of completed swaps; wraps at 16'hFFFF→0.
- `overrun`  out  1  sticky flag: a generation was due while the previous one was still computing.

## Operation
FSM states: IDLE, COMPUTE, READY.
- `due` = `frame_start` && ((`run` && `div_cnt`==GEN_DIV-1) || `step_pend`).
- `div_cnt`: increments on each `frame_start` while `run`=1. Wraps at GEN_DIV-1. Held when `run`=0.
- `step_pend`: set by `step` while `run`=0. Cleared when IDLE consumes `due`. Ignored while `run`=1.
- IDLE → COMPUTE on `due`. `gen_start` is pulsed the cycle after.
- COMPUTE → READY on `gen_done`. `gen_done` is ignored in IDLE and READY.
- COMPUTE with `due` true: set `overrun`, skip that trigger, stay in COMPUTE. `overrun` is cleared only by reset.
- READY → IDLE on `frame_start`: toggle `front_bank` and increment `generation` on the same edge. The same `frame_start` never starts a new generation.

Arbitration (combinational, every cycle):
- Display wins: `disp_req`=1 → `mem_en`=1, `mem_we`=0, `mem_addr`={`front_bank`,`disp_addr`}.
- Otherwise `eng_gnt` = `eng_req` && state==COMPUTE.
- Engine read → `mem_addr`={`front_bank`,`eng_addr`}.
- Engine write → `mem_addr`={~`front_bank`,`eng_addr`}, `mem_we`=1, `mem_wdata`=`eng_wdata`.
- No grant → `mem_en`=0, `mem_we`=0.
- Engine requests outside COMPUTE are never granted. The engine holds the request until `eng_gnt`.
- `disp_rdata` = `eng_rdata` = `mem_rdata` (pass-through). Only the matching rvalid qualifies the data.

## Timing
- Reset (`reset_n`=0 at a `clk` edge): state IDLE, `front_bank`=0, `generation`=0, `overrun`=0, `gen_start`=0, `disp_rvalid`=0, `eng_rvalid`=0, `div_cnt`=0, `step_pend`=0. While `reset_n`=0, `mem_en`=`mem_we`=`eng_gnt`=0.
- Reset mid-COMPUTE aborts the generation. The back bank contents are undefined. The engine shares `reset_n`.
- `disp_rvalid` is asserted exactly 1 cycle after a display grant. `eng_rvalid` is asserted exactly 1 cycle after an engine read grant, and never after a write.
- `gen_start` is asserted 1 cycle after the `due` edge.
- `front_bank` changes 1 cycle after the READY `frame_start` edge, which is inside vblank.
- `gen_done` and `frame_start` in the same cycle while in COMPUTE: go to READY. The swap waits for the next `frame_start`.
- GEN_DIV=1 with `run`=1: at most one generation every 2 frames (trigger frame, then swap frame).

## Structure
- Shared package `life_sched_pkg`:
  - state enum {IDLE, COMPUTE, READY};
  - default `ADDR_W`/`DATA_W`;
  - `GEN_W`=16.
- One sub-module, `grid_port_mux`: the combinational arbitration/address-bank mux plus the two registered rvalid flags.
- FSM, divider and counters live in the top module.

## Test plan
- Reset, then `run`=1, GEN_DIV=2, engine answers `gen_done` 100 cycles after `gen_start` → `gen_start` on every 2nd `frame_start`; `front_bank` toggles 0→1→0; `generation` 0→1→2.
- `disp_req` and `eng_req` (read, addr 5) asserted together during COMPUTE with `front_bank`=0 → `mem_addr`={0,`disp_addr`}, `eng_gnt`=0. On `disp_req` drop → `eng_gnt`=1, `mem_addr`=7'h05, `eng_rvalid`=1 next cycle.
- Engine write addr 3, data 1, `front_bank`=1 → `mem_addr`=7'h03, `mem_we`=1. The display never sees bank 0 until after the swap.
- `gen_done` withheld past the next due `frame_start` → `overrun`=1 and stays 1. No second `gen_start`. The state remains COMPUTE.
- `run`=0, `step` pulse → exactly one `gen_start` at the next `frame_start`. `generation` increments once, then the block stays IDLE.
- `reset_n`=0 for 1 cycle mid-COMPUTE with `front_bank`=1 → all outputs return to their reset values, including `front_bank`=0.
